// File: rtl/slave_port.sv
// Serial-bus responder: deserialises device select, address and write data, strobes a local
// byte memory and returns read data serially. Optional read split behind `SLAVE_SPLIT_EN.
module slave_port #(
  parameter int unsigned           DEV_BITS     = 4,
  parameter logic [DEV_BITS-1:0]   DEV_ID       = '0,
  parameter int unsigned           ADDR_W       = 12,
  parameter int unsigned           TIMEOUT      = 64,
  parameter int unsigned           SPLIT_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              wr_bus,
  output logic              rd_bus,
  output logic              ack,
  input  logic              master_valid,
  output logic              slave_ready,
  input  logic              master_ready,
  output logic              slave_valid,
  output logic              split,
  output logic [ADDR_W-1:0] s_addr,
  output logic [7:0]        s_wr_data,
  output logic              s_wr_en,
  output logic              s_rd_en,
  input  logic [7:0]        s_rd_data,
  input  logic              s_rd_valid
);

  // Shift register holds everything but the newest bit, which comes straight off wr_bus.
  localparam int unsigned SH_A   = (ADDR_W - 1 > 7) ? ADDR_W - 1 : 7;
  localparam int unsigned SH_W   = (SH_A > DEV_BITS) ? SH_A : DEV_BITS;
  localparam int unsigned TMR_MX = (TIMEOUT > SPLIT_THRESH) ? TIMEOUT : SPLIT_THRESH;
  localparam int unsigned TMR_W  = $clog2(TMR_MX + 1);

  typedef enum logic [3:0] {
    IDLE, DEV_SEL, DEC, ADDR, WR_DATA, WRITE, RD_REQ, RD_WAIT, RD_DATA, SPLIT
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [7:0]          rd_q, rd_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [7:0]          s_wr_data_q, s_wr_data_d;

  logic                bit_in;
  logic [SH_W:0]       sh_in;
  logic [3:0]          cnt_inc;

  assign slave_ready = state_q inside {IDLE, DEV_SEL, ADDR, WR_DATA};
  assign bit_in      = master_valid & slave_ready;
  assign sh_in       = {sh_q, wr_bus};
  assign cnt_inc     = cnt_q + 4'd1;
  assign rd_bus      = rd_q[7];
  assign s_addr      = s_addr_q;
  assign s_wr_data   = s_wr_data_q;

`ifdef SLAVE_SPLIT_EN
  assign split = (state_q == SPLIT) && !s_rd_valid;
`else
  assign split = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    s_addr_d    = s_addr_q;
    s_wr_data_d = s_wr_data_q;
    ack         = 1'b0;
    slave_valid = 1'b0;
    s_wr_en     = 1'b0;
    s_rd_en     = 1'b0;

    // Inbound phases abort when the master stalls too long between bits.
    if (state_q inside {DEV_SEL, ADDR, WR_DATA} && !bit_in) begin
      tmr_d = tmr_q + 1'b1;
      if (tmr_q == TMR_W'(TIMEOUT - 1)) state_d = IDLE;
    end

    unique case (state_q)
      IDLE: if (bit_in) begin
        sh_d    = sh_in[SH_W-1:0];
        state_d = (DEV_BITS == 1) ? DEC : DEV_SEL;
      end
      // cnt_q counts device bits beyond the first one taken in IDLE.
      DEV_SEL: if (bit_in) begin
        sh_d  = sh_in[SH_W-1:0];
        cnt_d = cnt_inc;
        tmr_d = '0;
        if (cnt_inc == 4'(DEV_BITS - 1)) state_d = DEC;
      end
      DEC: begin
        ack     = (sh_q[DEV_BITS-1:0] == DEV_ID);
        state_d = ack ? ADDR : IDLE;
      end
      ADDR: if (bit_in) begin
        sh_d  = sh_in[SH_W-1:0];
        cnt_d = cnt_inc;
        tmr_d = '0;
        if (cnt_inc == 4'(ADDR_W)) begin
          s_addr_d = sh_in[ADDR_W-1:0];
          state_d  = mode ? WR_DATA : RD_REQ;
        end
      end
      WR_DATA: if (bit_in) begin
        sh_d  = sh_in[SH_W-1:0];
        cnt_d = cnt_inc;
        tmr_d = '0;
        if (cnt_inc == 4'd8) begin
          s_wr_data_d = sh_in[7:0];
          state_d     = WRITE;
        end
      end
      WRITE: begin
        s_wr_en = 1'b1;
        state_d = IDLE;
      end
      RD_REQ: begin
        s_rd_en = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (s_rd_valid) begin
          rd_d    = s_rd_data;
          state_d = RD_DATA;
        end
`ifdef SLAVE_SPLIT_EN
        else begin
          tmr_d = tmr_q + 1'b1;
          if (tmr_q == TMR_W'(SPLIT_THRESH - 1)) state_d = SPLIT;
        end
`endif
      end
      SPLIT: if (s_rd_valid) begin
        rd_d    = s_rd_data;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        slave_valid = 1'b1;
        if (master_ready) begin
          rd_d  = {rd_q[6:0], 1'b0};
          cnt_d = cnt_inc;
          if (cnt_inc == 4'd8) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      tmr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      sh_q        <= '0;
      rd_q        <= '0;
      s_addr_q    <= '0;
      s_wr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      s_addr_q    <= s_addr_d;
      s_wr_data_q <= s_wr_data_d;
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port (DEV_ID=3): stimulus pushes expected bus events,
// a monitor pops and compares them as the DUT produces them.
module tb_slave_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        wr_bus = 1'b0;
  logic        rd_bus;
  logic        ack;
  logic        master_valid = 1'b0;
  logic        slave_ready;
  logic        master_ready = 1'b1;
  logic        slave_valid;
  logic        split;
  logic [11:0] s_addr;
  logic [7:0]  s_wr_data;
  logic        s_wr_en;
  logic        s_rd_en;
  logic [7:0]  s_rd_data = 8'h00;
  logic        s_rd_valid = 1'b0;

  slave_port #(.DEV_BITS(4), .DEV_ID(4'h3), .ADDR_W(12), .TIMEOUT(64), .SPLIT_THRESH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus), .ack(ack),
    .master_valid(master_valid), .slave_ready(slave_ready), .master_ready(master_ready),
    .slave_valid(slave_valid), .split(split), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_wr_en(s_wr_en), .s_rd_en(s_rd_en), .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
  );

  always #5 clk = ~clk;

  typedef enum {EV_ACK, EV_WR, EV_RD_REQ, EV_RD_BYTE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [11:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t sb_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  rd_lat = 2;
  logic [7:0] rd_val = 8'h00;
  bit  mr_stall = 1'b0;
  int  split_cnt = 0;
  int  split_first = 0;
  int  rd_en_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [11:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [11:0] a, input logic [7:0] d);
    ev_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d with none queued (t=%0t)", k, $time);
    end else begin
      e = sb_q.pop_front();
      check("event_kind", k, e.kind);
      if (k == EV_WR || k == EV_RD_REQ) check("event_addr", a, e.addr);
      if (k == EV_WR || k == EV_RD_BYTE) check("event_data", d, e.data);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every DUT-side event is compared against the scoreboard.
  initial begin : monitor
    logic [7:0] rd_sh = 8'h00;
    int rd_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_n = 0;
      end else begin
        if (ack) expect_ev(EV_ACK, 12'h0, 8'h0);
        if (s_wr_en) expect_ev(EV_WR, s_addr, s_wr_data);
        if (s_rd_en) begin
          rd_en_cyc = cyc;
          expect_ev(EV_RD_REQ, s_addr, 8'h0);
        end
        if (split) begin
          if (split_cnt == 0) split_first = cyc;
          split_cnt++;
        end
        if (slave_valid && master_ready) begin
          rd_sh = {rd_sh[6:0], rd_bus};
          rd_n++;
          if (rd_n == 8) begin
            rd_n = 0;
            expect_ev(EV_RD_BYTE, 12'h0, rd_sh);
          end
        end
      end
    end
  end

  // Local memory model: returns rd_val rd_lat cycles after the read strobe.
  initial forever begin
    @(negedge clk);
    if (s_rd_en) begin
      repeat (rd_lat) @(posedge clk);
      #1 s_rd_valid = 1'b1;
      s_rd_data = rd_val;
      @(posedge clk);
      #1 s_rd_valid = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1 master_ready = mr_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Drives n bits of v MSB first, holding each until slave_ready accepts it.
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      int   b = 0;
      logic r;
      master_valid = 1'b1;
      wr_bus       = v[i];
      do begin
        @(negedge clk);
        r = slave_ready;
        @(posedge clk);
        #1;
        b++;
      end while (!r && b < 50);
      if (!r) check("bit_accept_timeout", 0, 1);
    end
    master_valid = 1'b0;
    wr_bus       = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    while (sb_q.size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] dev, input logic [11:0] a, input logic [7:0] d,
                          input int gap);
    if (dev == 4'h3) begin
      push(EV_ACK, 12'h0, 8'h0);
      push(EV_WR, a, d);
    end
    send_bits({12'h0, dev}, 4);
    if (dev != 4'h3) begin
      @(negedge clk);
      check("nomatch_ack", ack, 1'b0);
      check("nomatch_dec_ready", slave_ready, 1'b0);
      @(negedge clk);
      check("nomatch_idle_ready", slave_ready, 1'b1);
      @(posedge clk);
      #1;
    end else begin
      mode = 1'b1;
      if (gap > 0) begin
        send_bits({4'h0, a} >> 7, 5);
        repeat (gap) @(posedge clk);
        #1;
        send_bits({4'h0, a}, 7);
      end else begin
        send_bits({4'h0, a}, 12);
      end
      send_bits({8'h0, d}, 8);
      wait_done();
    end
  endtask

  task automatic do_read(input logic [11:0] a, input logic [7:0] d, input int lat, input bit stall);
    rd_lat   = lat;
    rd_val   = d;
    mr_stall = stall;
    push(EV_ACK, 12'h0, 8'h0);
    push(EV_RD_REQ, a, 8'h0);
    push(EV_RD_BYTE, 12'h0, d);
    send_bits(16'h3, 4);
    mode = 1'b0;
    send_bits({4'h0, a}, 12);
    wait_done();
    mr_stall = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_slave_ready", slave_ready, 1'b1);
    check("rst_ack", ack, 1'b0);
    check("rst_slave_valid", slave_valid, 1'b0);
    check("rst_wr_en", s_wr_en, 1'b0);
    check("rst_rd_en", s_rd_en, 1'b0);
    check("rst_split", split, 1'b0);
    check("rst_addr", s_addr, 12'h0);
    check("rst_wr_data", s_wr_data, 8'h0);
    check("rst_rd_bus", rd_bus, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_write(4'h3, 12'h0A5, 8'hC3, 0);
    do_write(4'h5, 12'h000, 8'h00, 0);
    do_read(12'h010, 8'h5A, 2, 1'b0);
    do_read(12'h7E1, 8'hA7, 1, 1'b1);
    check("no_split_short_reads", split_cnt, 0);

`ifdef SLAVE_SPLIT_EN
    split_cnt = 0;
    do_read(12'h123, 8'h96, 20, 1'b0);
    check("split_cycles", split_cnt, 11);
    check("split_start_offset", split_first - rd_en_cyc, 9);
    split_cnt = 0;
    do_read(12'h124, 8'h69, 8, 1'b0);
    check("threshold_valid_no_split", split_cnt, 0);
`else
    do_read(12'h123, 8'h96, 20, 1'b0);
    check("split_tied_low", split_cnt, 0);
`endif

    // 63 idle cycles mid-address must not abort.
    do_write(4'h3, 12'h5C3, 8'h3C, 63);

    // 64 idle cycles mid-address aborts silently.
    push(EV_ACK, 12'h0, 8'h0);
    send_bits(16'h3, 4);
    mode = 1'b1;
    send_bits(16'h00A >> 0, 5);
    repeat (64) @(posedge clk);
    #1;
    @(negedge clk);
    check("timeout_ready", slave_ready, 1'b1);
    check("timeout_sb_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
    do_write(4'h3, 12'h321, 8'h81, 0);

    // Reset in the middle of write data.
    push(EV_ACK, 12'h0, 8'h0);
    send_bits(16'h3, 4);
    mode = 1'b1;
    send_bits(16'h0ABC, 12);
    send_bits(16'h000E, 4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", slave_ready, 1'b1);
    check("midrst_addr", s_addr, 12'h0);
    check("midrst_wr_data", s_wr_data, 8'h0);
    check("midrst_wr_en", s_wr_en, 1'b0);
    check("midrst_ack", ack, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_sb_empty", sb_q.size(), 0);
    do_write(4'h3, 12'h456, 8'hE7, 0);

    repeat (5) @(posedge clk);
    check("final_sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
